// File: rtl/uart_pkg.sv
// Shared definitions for the oversampled UART receiver.
// Holds the state encoding, the default oversample ratio and the parity-check helper.
package uart_pkg;

    localparam int UART_SAMPLE_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // data_xor is the XOR-reduction of the received data word.
    function automatic logic parity_mismatch(input logic data_xor, input logic sample, input logic odd);
        return (data_xor ^ sample) != odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus a delayed copy for falling-edge detection.
// Every flop resets to 1 so that a reset never produces a false start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic meta_r;
    logic rx_s_d_r;

    // Synchroniser chain followed by the one-clock delayed copy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r   <= 1'b1;
            rx_s     <= 1'b1;
            rx_s_d_r <= 1'b1;
        end else begin
            meta_r   <= rx;
            rx_s     <= meta_r;
            rx_s_d_r <= rx_s;
        end
    end

    assign fall = rx_s_d_r & ~rx_s;

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: start-edge detection, mid-bit sampling, optional parity and
// stop-bit checking, one word per frame with a single-clock done strobe.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int SAMPLE     = UART_SAMPLE_DEF,
    parameter int DBIT       = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_done,
    output logic            frame_err,
    output logic            parity_err,
    output logic            busy
);

    localparam int SW = (SAMPLE > 1) ? $clog2(SAMPLE) : 1;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_MID   = SW'(SAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST  = SW'(SAMPLE - 1);
    localparam logic [NW-1:0] N_DLAST = NW'(DBIT - 1);
    localparam logic [NW-1:0] N_SLAST = NW'(STOP_BITS - 1);
    localparam logic          PAR_ON  = (PARITY_EN != 0);
    localparam logic          PAR_ODD = (PARITY_ODD != 0);

    logic            rx_s;
    logic            fall;
    rx_state_t       state_r;
    logic [SW-1:0]   s_cnt_r;
    logic [NW-1:0]   n_cnt_r;
    logic [DBIT-1:0] shreg_r;
    logic            ferr_r;
    logic            perr_r;

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (rx),
        .rx_s    (rx_s),
        .fall    (fall)
    );

    // Receive FSM with registered outputs; all counting is gated by s_tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            s_cnt_r    <= '0;
            n_cnt_r    <= '0;
            shreg_r    <= '0;
            ferr_r     <= 1'b0;
            perr_r     <= 1'b0;
            rx_dout    <= '0;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // Only a real falling edge starts a frame; a held-low line (break) does not.
                    if (fall) begin
                        state_r <= ST_START;
                        s_cnt_r <= '0;
                        ferr_r  <= 1'b0;
                        perr_r  <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (s_tick) begin
                        if (s_cnt_r == S_MID) begin
                            s_cnt_r <= '0;
                            if (!rx_s) begin
                                state_r <= ST_DATA;
                                n_cnt_r <= '0;
                            end else begin
                                state_r <= ST_IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            s_cnt_r <= s_cnt_r + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (s_tick) begin
                        if (s_cnt_r == S_LAST) begin
                            shreg_r <= {rx_s, shreg_r[DBIT-1:1]};
                            s_cnt_r <= '0;
                            if (n_cnt_r == N_DLAST) begin
                                n_cnt_r <= '0;
                                state_r <= PAR_ON ? ST_PARITY : ST_STOP;
                            end else begin
                                n_cnt_r <= n_cnt_r + 1'b1;
                            end
                        end else begin
                            s_cnt_r <= s_cnt_r + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (s_tick) begin
                        if (s_cnt_r == S_LAST) begin
                            perr_r  <= parity_mismatch(^shreg_r, rx_s, PAR_ODD);
                            state_r <= ST_STOP;
                            s_cnt_r <= '0;
                            n_cnt_r <= '0;
                        end else begin
                            s_cnt_r <= s_cnt_r + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (s_tick) begin
                        if (s_cnt_r == S_LAST) begin
                            s_cnt_r <= '0;
                            if (!rx_s) begin
                                ferr_r <= 1'b1;
                            end
                            // Leaving at mid-stop-bit lets a back-to-back start edge be seen.
                            if (n_cnt_r == N_SLAST) begin
                                n_cnt_r    <= '0;
                                state_r    <= ST_IDLE;
                                busy       <= 1'b0;
                                rx_dout    <= shreg_r;
                                frame_err  <= ferr_r | ~rx_s;
                                parity_err <= perr_r;
                                rx_done    <= 1'b1;
                            end else begin
                                n_cnt_r <= n_cnt_r + 1'b1;
                            end
                        end else begin
                            s_cnt_r <= s_cnt_r + 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    s_cnt_r <= '0;
                    n_cnt_r <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled: directed vector table, corner-case sequences
// and randomized frames compared against a frame-level reference model.
module tb_uart_rx_oversampled;

    localparam int BIT_CLK = 128;

    typedef struct packed {
        logic [7:0] dout;
        logic       ferr;
        logic       perr;
    } res_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap_bits;
        logic [7:0] exp_dout;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic       rx_p = 1'b1;
    logic [7:0] rx_dout, rx_dout_p;
    logic       rx_done, rx_done_p;
    logic       frame_err, frame_err_p;
    logic       parity_err, parity_err_p;
    logic       busy, busy_p;

    int   n_tests = 0;
    int   n_fail = 0;
    res_t got_q[$];
    res_t got_p_q[$];
    res_t exp_q[$];
    res_t exp_p_q[$];
    vec_t vecs[4];

    uart_rx_oversampled #(.SAMPLE(32), .DBIT(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx),
        .rx_dout(rx_dout), .rx_done(rx_done), .frame_err(frame_err),
        .parity_err(parity_err), .busy(busy)
    );

    uart_rx_oversampled #(.SAMPLE(32), .DBIT(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_p (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx_p),
        .rx_dout(rx_dout_p), .rx_done(rx_done_p), .frame_err(frame_err_p),
        .parity_err(parity_err_p), .busy(busy_p)
    );

    always #5 clk = ~clk;

    // Oversample strobe: one clock high every four clocks.
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    // Collect every completed frame from both receivers.
    always @(negedge clk) begin
        if (rx_done) got_q.push_back({rx_dout, frame_err, parity_err});
        if (rx_done_p) got_p_q.push_back({rx_dout_p, frame_err_p, parity_err_p});
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Frame-level reference: data passes through, stop bit low flags a framing error,
    // even parity is violated when data plus parity bit hold an odd number of ones.
    function automatic res_t model(input logic [7:0] d, input logic stop, input bit par_en,
                                   input logic par_bit);
        res_t r;
        r.dout = d;
        r.ferr = (stop == 1'b0);
        r.perr = par_en ? (($countones({d, par_bit}) % 2) == 1) : 1'b0;
        return r;
    endfunction

    task automatic drive_bit(input bit on_p, input logic v, input int nclk);
        if (on_p) rx_p = v;
        else rx = v;
        repeat (nclk) @(negedge clk);
    endtask

    task automatic send_frame(input bit on_p, input logic [7:0] d, input logic stop,
                              input bit par_en, input logic par_bit);
        drive_bit(on_p, 1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) drive_bit(on_p, d[i], BIT_CLK);
        if (par_en) drive_bit(on_p, par_bit, BIT_CLK);
        drive_bit(on_p, stop, BIT_CLK);
    endtask

    task automatic wait_count(input bit on_p, input int n, input string name);
        int sz;
        for (int c = 0; c < 600; c++) begin
            sz = on_p ? got_p_q.size() : got_q.size();
            if (sz >= n) break;
            @(negedge clk);
        end
        sz = on_p ? got_p_q.size() : got_q.size();
        check(name, sz, n);
    endtask

    task automatic compare_res(input string name, input bit on_p, input res_t exp);
        res_t r;
        r = '1;
        if (on_p && got_p_q.size() > 0) r = got_p_q.pop_front();
        else if (!on_p && got_q.size() > 0) r = got_q.pop_front();
        check({name, " dout"}, r.dout, exp.dout);
        check({name, " frame_err"}, r.ferr, exp.ferr);
        check({name, " parity_err"}, r.perr, exp.perr);
    endtask

    initial begin
        logic [7:0] d;
        logic       stop;
        logic       pb;
        int         gap;
        res_t       e;

        vecs[0] = '{data: 8'hA5, stop: 1'b1, gap_bits: 2, exp_dout: 8'hA5, exp_ferr: 1'b0, exp_perr: 1'b0};
        vecs[1] = '{data: 8'h00, stop: 1'b1, gap_bits: 0, exp_dout: 8'h00, exp_ferr: 1'b0, exp_perr: 1'b0};
        vecs[2] = '{data: 8'hFF, stop: 1'b1, gap_bits: 0, exp_dout: 8'hFF, exp_ferr: 1'b0, exp_perr: 1'b0};
        vecs[3] = '{data: 8'h3C, stop: 1'b1, gap_bits: 1, exp_dout: 8'h3C, exp_ferr: 1'b0, exp_perr: 1'b0};

        // Reset state with idle line.
        repeat (5) @(negedge clk);
        check("reset rx_dout", rx_dout, 8'h00);
        check("reset rx_done", rx_done, 1'b0);
        check("reset frame_err", frame_err, 1'b0);
        check("reset parity_err", parity_err, 1'b0);
        check("reset busy", busy, 1'b0);
        reset_n = 1'b1;
        repeat (500) @(negedge clk);
        check("idle no rx_done", got_q.size(), 0);
        check("idle busy", busy, 1'b0);

        // Single frame, then three frames back to back.
        for (int i = 0; i < 4; i++) begin
            send_frame(1'b0, vecs[i].data, vecs[i].stop, 1'b0, 1'b0);
            drive_bit(1'b0, 1'b1, vecs[i].gap_bits * BIT_CLK);
            if (i == 0) begin
                check("single frame count", got_q.size(), 1);
                check("single frame busy falls", busy, 1'b0);
            end
        end
        wait_count(1'b0, 4, "table count");
        for (int i = 0; i < 4; i++)
            compare_res($sformatf("table[%0d]", i), 1'b0,
                        '{dout: vecs[i].exp_dout, ferr: vecs[i].exp_ferr, perr: vecs[i].exp_perr});

        // Framing error followed by a 20-bit break.
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b0, 20 * BIT_CLK);
        drive_bit(1'b0, 1'b1, 2 * BIT_CLK);
        check("break single done", got_q.size(), 1);
        check("break busy", busy, 1'b0);
        compare_res("frame_err 0x55", 1'b0, model(8'h55, 1'b0, 1'b0, 1'b0));
        send_frame(1'b0, 8'h5A, 1'b1, 1'b0, 1'b0);
        wait_count(1'b0, 1, "after break count");
        compare_res("after break 0x5A", 1'b0, model(8'h5A, 1'b1, 1'b0, 1'b0));

        // Short low glitch must not start a frame.
        drive_bit(1'b0, 1'b0, 40);
        drive_bit(1'b0, 1'b1, 3 * BIT_CLK);
        check("glitch no done", got_q.size(), 0);
        check("glitch busy", busy, 1'b0);

        // Even parity on the parity-enabled receiver.
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 1'b1, BIT_CLK);
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        drive_bit(1'b1, 1'b1, BIT_CLK);
        wait_count(1'b1, 2, "parity count");
        compare_res("parity bad 0x07", 1'b1, '{dout: 8'h07, ferr: 1'b0, perr: 1'b1});
        compare_res("parity good 0x07", 1'b1, '{dout: 8'h07, ferr: 1'b0, perr: 1'b0});
        check("parity busy", busy_p, 1'b0);

        // Randomized frames on both receivers against the reference model.
        for (int k = 0; k < 16; k++) begin
            d = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            send_frame(1'b0, d, stop, 1'b0, 1'b0);
            exp_q.push_back(model(d, stop, 1'b0, 1'b0));
            gap = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
            drive_bit(1'b0, 1'b1, gap * BIT_CLK);
        end
        wait_count(1'b0, 16, "random count");
        for (int k = 0; k < 16; k++) begin
            e = exp_q.pop_front();
            compare_res($sformatf("random[%0d]", k), 1'b0, e);
        end
        for (int k = 0; k < 8; k++) begin
            d = 8'($urandom_range(0, 255));
            pb = 1'($urandom_range(0, 1));
            send_frame(1'b1, d, 1'b1, 1'b1, pb);
            exp_p_q.push_back(model(d, 1'b1, 1'b1, pb));
            drive_bit(1'b1, 1'b1, $urandom_range(0, 1) * BIT_CLK);
        end
        wait_count(1'b1, 8, "random parity count");
        for (int k = 0; k < 8; k++) begin
            e = exp_p_q.pop_front();
            compare_res($sformatf("random parity[%0d]", k), 1'b1, e);
        end

        // Reset in the middle of data bit 4.
        drive_bit(1'b0, 1'b0, BIT_CLK);
        d = 8'hC3;
        for (int i = 0; i < 4; i++) drive_bit(1'b0, d[i], BIT_CLK);
        drive_bit(1'b0, d[4], BIT_CLK / 2);
        check("mid frame busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid reset rx_dout", rx_dout, 8'h00);
        check("mid reset busy", busy, 1'b0);
        check("mid reset frame_err", frame_err, 1'b0);
        check("mid reset rx_done", rx_done, 1'b0);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        reset_n = 1'b1;
        drive_bit(1'b0, 1'b1, 2 * BIT_CLK);
        check("mid reset no done", got_q.size(), 0);
        send_frame(1'b0, 8'h81, 1'b1, 1'b0, 1'b0);
        wait_count(1'b0, 1, "post reset count");
        compare_res("post reset 0x81", 1'b0, model(8'h81, 1'b1, 1'b0, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
